id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the instruction word inserted as a bubble.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port inst  input  32  fetched instruction from fetch stage, same cycle as if_pc.
REQ-005 SHALL have port if_pc  input  10  byte address of inst.
REQ-006 SHALL have port taken  input  1  branch resolved taken; flush younger instructions.
REQ-007 SHALL have port wb_we, wb_rd, wb_data  input  1/5/32  writeback write enable, destination, data.
REQ-008 SHALL have port stall  output  1  load-use hazard; fetch holds PC this cycle.
REQ-009 SHALL have port halting  output  1  sticky halt request to fetch.
REQ-010 SHALL have ports ex_valid 1, ex_pc 10, ex_rs1_data 32, ex_rs2_data 32, ex_imm 32, ex_rs1 5, ex_rs2 5, ex_rd 5, ex_opcode 7, ex_funct3 3, ex_funct7b5 1  output  ID/EX register contents.

Function
REQ-011 SHALL register inst/if_pc into an IF/ID register with valid bit each cycle unless stall or halting is high.
REQ-012 SHALL, when taken=1, load NOP_INST with valid=0 into IF/ID and load a bubble (ex_valid=0, ex_rd=0) into ID/EX, regardless of stall.
REQ-013 SHALL decode from the IF/ID register combinationally: rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0], funct3=[14:12], funct7b5=[30].
REQ-014 SHALL generate sign-extended ex_imm by opcode: I (0000011,0010011,1100111,1110011), S (0100011), B (1100011, bit0=0), U (0110111,0010111, low 12 zero), J (1101111, bit0=0); all others 0.
REQ-015 SHALL force rd=0 in ID/EX for S and B opcodes.
REQ-016 SHALL contain a 32x32 register file, 2 async read ports, 1 sync write port; write when wb_we=1 and wb_rd!=0.
REQ-017 SHALL return 0 for any read of x0; x0 SHALL never be written.
REQ-018 SHALL assert stall combinationally when ID/EX holds a valid load (opcode 0000011, ex_rd!=0) and ex_rd equals decoded rs1 or rs2 of a valid IF/ID instruction.
REQ-019 SHALL, while stall=1 and taken=0, hold IF/ID and load a bubble into ID/EX; stall lasts exactly one cycle per hazard.
REQ-020 SHALL set halting=1 on the cycle after a valid EBREAK (32'h0010_0073) is loaded into ID/EX; halting stays 1 until reset.
REQ-021 SHALL, while halting=1, hold both IF/ID and ID/EX contents, except a coincident taken still flushes.
REQ-022 SHALL have latency of one cycle from IF/ID capture to ID/EX output.

Reset
REQ-023 SHALL on rst_n=0 clear IF/ID to NOP_INST/valid=0/pc=0, clear all ID/EX outputs to 0, clear halting to 0, immediately and asynchronously.
REQ-024 SHALL leave register file contents undefined after reset except x0 reading 0.
REQ-025 SHALL, on reset mid-stall or mid-flush, discard the pending event; first post-reset capture is normal.

Configuration
REQ-026 SHALL, with ID_FORWARD_EN defined, bypass wb_data to a read port when wb_we=1, wb_rd!=0 and wb_rd equals that port's address in the same cycle.
REQ-027 SHALL, without ID_FORWARD_EN, return the stored register value (old data) on same-cycle read/write collision.

Verification
REQ-028 SHALL test: write x5=32'hDEAD_BEEF, then decode add x6,x5,x5 -> ex_rs1_data=ex_rs2_data=32'hDEAD_BEEF, ex_rd=6.
REQ-029 SHALL test: lw x3,0(x1) followed by add x4,x3,x2 -> stall=1 for exactly 1 cycle, one bubble with ex_valid=0, add reaches ID/EX next cycle.
REQ-030 SHALL test: taken=1 with beq in ID -> next cycle ex_valid=0, IF/ID valid=0; no stall even if hazard present.
REQ-031 SHALL test: same-cycle wb_we=1, wb_rd=7, wb_data=32'h1234 with decoded rs1=7 -> 32'h1234 with ID_FORWARD_EN, old value without.
REQ-032 SHALL test: EBREAK decoded -> halting=1 following cycle, outputs frozen 10 cycles; rst_n pulse -> halting=0, ex_valid=0.
REQ-033 SHALL test: write to x0 with 32'hFFFF_FFFF -> read of x0 returns 0; imm for sw x2,-4(x1) -> ex_imm=32'hFFFF_FFFC, ex_rd=0.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32 decode stage with IF/ID and ID/EX registers, register file, load-use stall and halt
// Optional feature macro: ID_FORWARD_EN bypasses same-cycle writeback data onto the read ports.
// Ports: clk, rst_n (async, active-low); inst/if_pc from fetch; taken flushes younger work;
//        wb_we/wb_rd/wb_data writeback; stall/halting back to fetch; ex_* are the ID/EX register.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [9:0]  if_pc,
  input  logic        taken,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        halting,
  output logic        ex_valid,
  output logic [9:0]  ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef struct packed {
    logic        valid;
    logic [9:0]  pc;
    logic [31:0] a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
  } ex_t;
  logic [31:0] fd_inst;
  logic [9:0]  fd_pc;
  logic        fd_valid;
  logic [31:0] regs [32];
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [31:0] imm, rs1_data, rs2_data;
  logic        hazard;
  ex_t         ex_q, ex_d;
  assign opcode = fd_inst[6:0];
  assign rs1    = fd_inst[19:15];
  assign rs2    = fd_inst[24:20];
  // stores and branches have no destination; keep them invisible to hazard/writeback logic
  assign rd     = (opcode == 7'b0100011 || opcode == 7'b1100011) ? 5'd0 : fd_inst[11:7];
  always_comb begin
    imm = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm = {{20{fd_inst[31]}}, fd_inst[31:20]};
      7'b0100011: imm = {{20{fd_inst[31]}}, fd_inst[31:25], fd_inst[11:7]};
      7'b1100011: imm = {{19{fd_inst[31]}}, fd_inst[31], fd_inst[7], fd_inst[30:25], fd_inst[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {fd_inst[31:12], 12'b0};
      7'b1101111: imm = {{11{fd_inst[31]}}, fd_inst[31], fd_inst[19:12], fd_inst[20], fd_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
`ifdef ID_FORWARD_EN
  assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];
`else
  assign rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2];
`endif
  always_ff @(posedge clk)
    if (wb_we && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
  assign hazard = ex_q.valid && ex_q.opcode == 7'b0000011 && ex_q.rd != 5'd0 && fd_valid &&
                  (ex_q.rd == rs1 || ex_q.rd == rs2);
  // a flush discards the dependent instruction, so fetch must not be held by it
  assign stall = hazard && !taken;
  assign ex_d = {fd_valid, fd_pc, rs1_data, rs2_data, imm, rs1, rs2, rd, opcode, fd_inst[14:12], fd_inst[30]};
  assign {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
          ex_opcode, ex_funct3, ex_funct7b5} = ex_q;
  // priority: flush, then halt freeze, then load-use bubble, then normal advance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fd_inst  <= NOP_INST;
      fd_pc    <= '0;
      fd_valid <= 1'b0;
      ex_q     <= '0;
      halting  <= 1'b0;
    end else if (taken) begin
      fd_inst  <= NOP_INST;
      fd_valid <= 1'b0;
      ex_q     <= '0;
    end else if (!halting) begin
      if (hazard) ex_q <= '0;
      else begin
        ex_q     <= ex_d;
        halting  <= fd_valid && fd_inst == EBREAK;
        fd_inst  <= inst;
        fd_pc    <= if_pc;
        fd_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: decode-stage bench with vector table, directed corner sequences and random checking
module tb_id_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [31:0] inst, wb_data;
  logic [9:0]  if_pc, pcn, epc;
  logic        taken, wb_we;
  logic [4:0]  wb_rd;
  logic        stall, halting, ex_valid, ex_funct7b5;
  logic [9:0]  ex_pc;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  id_stage dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .if_pc(if_pc), .taken(taken), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .halting(halting), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
  );
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  typedef struct { bit v; bit [31:0] i; bit [9:0] pc; } mfd_t;
  typedef struct {
    bit v; bit [9:0] pc; bit [31:0] a, b, imm; bit ka, kb;
    bit [4:0] rs1, rs2, rd; bit [6:0] op; bit [2:0] f3; bit f7;
  } mex_t;
  mfd_t m_if;
  mex_t m_ex, bub;
  bit m_halt;
  bit [31:0] regs [32];
  bit known [32];
  function automatic bit [31:0] imm_of(bit [31:0] i);
    int s, hi;
    s = int'(i);
    hi = s >>> 31;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: return 32'(s >>> 20);
      7'h23: return 32'(hi * 4096 + int'(i[31:25]) * 32 + int'(i[11:7]));
      7'h63: return 32'(hi * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return 32'(hi * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
      default: return 32'h0;
    endcase
  endfunction
  function automatic mex_t dec(mfd_t f);
    mex_t e;
    e.v = f.v; e.pc = f.pc; e.op = f.i[6:0]; e.f3 = f.i[14:12]; e.f7 = f.i[30];
    e.rs1 = f.i[19:15]; e.rs2 = f.i[24:20];
    e.rd = (e.op == 7'h23 || e.op == 7'h63) ? 5'd0 : f.i[11:7];
    e.imm = imm_of(f.i);
    e.a = regs[e.rs1]; e.ka = known[e.rs1];
    e.b = regs[e.rs2]; e.kb = known[e.rs2];
`ifdef ID_FORWARD_EN
    if (wb_we && wb_rd != 0 && wb_rd == e.rs1) begin e.a = wb_data; e.ka = 1; end
    if (wb_we && wb_rd != 0 && wb_rd == e.rs2) begin e.b = wb_data; e.kb = 1; end
`endif
    return e;
  endfunction
  task automatic tick();
    mfd_t nf; mex_t ne; bit nh, hz;
    #1;
    hz = m_ex.v && m_ex.op == 7'h03 && m_ex.rd != 0 && m_if.v &&
         (m_ex.rd == m_if.i[19:15] || m_ex.rd == m_if.i[24:20]);
    chk("stall", 32'(stall), 32'(hz && !taken));
    nf = m_if; ne = m_ex; nh = m_halt;
    if (taken) begin nf.v = 0; nf.i = NOP; ne = bub; end
    else if (!m_halt) begin
      if (hz) ne = bub;
      else begin
        ne = dec(m_if);
        nh = m_if.v && m_if.i == EBRK;
        nf.v = 1; nf.i = inst; nf.pc = if_pc;
      end
    end
    if (wb_we && wb_rd != 0) begin regs[wb_rd] = wb_data; known[wb_rd] = 1; end
    @(posedge clk);
    m_if = nf; m_ex = ne; m_halt = nh;
    @(negedge clk);
    chk("halting", 32'(halting), 32'(m_halt));
    chk("ex_valid", 32'(ex_valid), 32'(m_ex.v));
    chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
    if (m_ex.v) begin
      chk("ex_pc", 32'(ex_pc), 32'(m_ex.pc));
      chk("ex_opcode", 32'(ex_opcode), 32'(m_ex.op));
      chk("ex_funct3", 32'(ex_funct3), 32'(m_ex.f3));
      chk("ex_funct7b5", 32'(ex_funct7b5), 32'(m_ex.f7));
      chk("ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
      chk("ex_imm", ex_imm, m_ex.imm);
      if (m_ex.ka) chk("ex_rs1_data", ex_rs1_data, m_ex.a);
      if (m_ex.kb) chk("ex_rs2_data", ex_rs2_data, m_ex.b);
    end
  endtask
  task automatic feed(input logic [31:0] i);
    inst = i; if_pc = pcn; pcn = pcn + 10'd4;
  endtask
  task automatic do_reset();
    wb_we = 0; taken = 0;
    rst_n = 0;
    #1;
    chk("rst_halting", 32'(halting), 32'h0);
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_ex_rd", 32'(ex_rd), 32'h0);
    chk("rst_ex_pc", 32'(ex_pc), 32'h0);
    chk("rst_ex_imm", ex_imm, 32'h0);
    chk("rst_ex_opcode", 32'(ex_opcode), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    m_if.v = 0; m_if.i = NOP; m_if.pc = 0; m_ex = bub; m_halt = 0;
    for (int r = 0; r < 32; r++) known[r] = (r == 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic preload();
    for (int r = 1; r < 32; r++) begin
      wb_we = 1; wb_rd = 5'(r); wb_data = 32'hA500_0000 | r; tick();
    end
    wb_we = 0;
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    logic [6:0] op;
    i = $urandom;
    case ($urandom_range(0, 10))
      0: op = 7'h03; 1: op = 7'h13; 2: op = 7'h23; 3: op = 7'h33; 4: op = 7'h37;
      5: op = 7'h17; 6: op = 7'h63; 7: op = 7'h67; 8: op = 7'h6F; 9: op = 7'h73;
      default: op = i[6:0];
    endcase
    i[6:0] = op;
    i[11:7] = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return (i == EBRK) ? NOP : i;
  endfunction
  typedef struct { logic [31:0] i, imm; logic [4:0] rd, rs1, rs2; logic [6:0] op; } vec_t;
  vec_t tbl [12];
  initial begin
    tbl[0]  = '{32'hFFF1_0093, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd31, 7'h13};
    tbl[1]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd2, 7'h23};
    tbl[2]  = '{32'hFE20_8CE3, 32'hFFFF_FFF8, 5'd0, 5'd1, 5'd2, 7'h63};
    tbl[3]  = '{32'h1234_52B7, 32'h1234_5000, 5'd5, 5'd8, 5'd3, 7'h37};
    tbl[4]  = '{32'hFFFF_F0EF, 32'hFFFF_FFFE, 5'd1, 5'd31, 5'd31, 7'h6F};
    tbl[5]  = '{32'h0080_006F, 32'h0000_0008, 5'd0, 5'd0, 5'd8, 7'h6F};
    tbl[6]  = '{32'h0052_8333, 32'h0000_0000, 5'd6, 5'd5, 5'd5, 7'h33};
    tbl[7]  = '{32'h0000_A183, 32'h0000_0000, 5'd3, 5'd1, 5'd0, 7'h03};
    tbl[8]  = '{32'h8000_0117, 32'h8000_0000, 5'd2, 5'd0, 5'd0, 7'h17};
    tbl[9]  = '{32'h0FF0_000F, 32'h0000_0000, 5'd0, 5'd0, 5'd31, 7'h0F};
    tbl[10] = '{32'h0101_00E7, 32'h0000_0010, 5'd1, 5'd2, 5'd16, 7'h67};
    tbl[11] = '{32'h4052_8333, 32'h0000_0000, 5'd6, 5'd5, 5'd5, 7'h33};
    inst = NOP; if_pc = 0; pcn = 0; taken = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    @(negedge clk);
    do_reset();
    preload();
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF; tick();
    wb_rd = 5; wb_data = 32'hDEAD_BEEF; tick();
    wb_we = 0;
    for (int k = 0; k < 12; k++) begin
      feed(tbl[k].i); tick();
      feed(NOP); tick();
      chk("tbl_imm", ex_imm, tbl[k].imm);
      chk("tbl_rd", 32'(ex_rd), 32'(tbl[k].rd));
      chk("tbl_rs1", 32'(ex_rs1), 32'(tbl[k].rs1));
      chk("tbl_rs2", 32'(ex_rs2), 32'(tbl[k].rs2));
      chk("tbl_op", 32'(ex_opcode), 32'(tbl[k].op));
    end
    feed(32'h0052_8333); tick(); feed(NOP); tick();
    chk("add_x5_a", ex_rs1_data, 32'hDEAD_BEEF);
    chk("add_x5_b", ex_rs2_data, 32'hDEAD_BEEF);
    chk("add_rd", 32'(ex_rd), 32'd6);
    feed(32'h0000_0333); tick(); feed(NOP); tick();
    chk("x0_read_a", ex_rs1_data, 32'h0);
    chk("x0_read_b", ex_rs2_data, 32'h0);
    feed(32'h0000_A183); tick(); feed(32'h0021_8233); tick(); feed(NOP);
    #1 chk("lu_stall_on", 32'(stall), 32'h1);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'h0);
    #1 chk("lu_stall_off", 32'(stall), 32'h0);
    tick();
    chk("lu_add_valid", 32'(ex_valid), 32'h1);
    chk("lu_add_rd", 32'(ex_rd), 32'd4);
    feed(32'h0000_A183); tick(); feed(32'hFE21_8CE3); tick();
    feed(32'h0021_8233); taken = 1;
    #1 chk("flush_nostall", 32'(stall), 32'h0);
    tick(); taken = 0;
    chk("flush_ex_valid", 32'(ex_valid), 32'h0);
    chk("flush_ex_rd", 32'(ex_rd), 32'h0);
    feed(NOP); tick();
    chk("flush_ifid_valid", 32'(ex_valid), 32'h0);
    feed(32'h0003_8433); tick();
    feed(NOP); wb_we = 1; wb_rd = 7; wb_data = 32'h1234; tick(); wb_we = 0;
`ifdef ID_FORWARD_EN
    chk("wb_collision", ex_rs1_data, 32'h0000_1234);
`else
    chk("wb_collision", ex_rs1_data, 32'hA500_0007);
`endif
    feed(EBRK); epc = if_pc; tick(); feed(NOP); tick();
    chk("halt_set", 32'(halting), 32'h1);
    chk("halt_ebreak_op", 32'(ex_opcode), 32'h73);
    for (int k = 0; k < 10; k++) begin
      feed(rnd_inst()); tick();
      chk("halt_frozen_pc", 32'(ex_pc), 32'(epc));
      chk("halt_frozen_imm", ex_imm, 32'h1);
      chk("halt_frozen_valid", 32'(ex_valid), 32'h1);
    end
    taken = 1; tick(); taken = 0;
    chk("halt_flush_valid", 32'(ex_valid), 32'h0);
    chk("halt_sticky", 32'(halting), 32'h1);
    do_reset();
    feed(32'h0000_A183); tick(); feed(32'h0021_8233); tick();
    do_reset();
    feed(32'h0021_8233); tick(); feed(NOP); tick();
    chk("post_rst_valid", 32'(ex_valid), 32'h1);
    chk("post_rst_rd", 32'(ex_rd), 32'd4);
    preload();
    for (int n = 0; n < 3000; n++) begin
      feed(rnd_inst());
      taken = ($urandom_range(0, 15) == 0);
      wb_we = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      tick();
    end
    taken = 0; wb_we = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
